// File: rtl/volume_level_ctrl_pkg.sv
// Shared definitions for the microphone volume meter: sizes, FSM encoding,
// the sample-magnitude helper and the LED bar decoder.
package volume_level_ctrl_pkg;

    localparam int LEVEL_W  = 4;
    localparam int SAMPLE_W = 12;
    localparam int CNT_W    = 16;
    localparam int LED_W    = 16;

    localparam logic [SAMPLE_W-1:0] MAG_CLAMP = 12'd2047;

    typedef enum logic [1:0] {
        ST_ACQ     = 2'b00,
        ST_QUANT   = 2'b01,
        ST_PUBLISH = 2'b10
    } state_e;

    // Distance from the silence code, limited to the positive 12-bit signed range.
    function automatic logic [SAMPLE_W-1:0] sample_mag(
        input logic [SAMPLE_W-1:0] sample,
        input logic [SAMPLE_W-1:0] mid
    );
        logic [SAMPLE_W-1:0] diff;
        if (sample >= mid) begin
            diff = sample - mid;
        end else begin
            diff = mid - sample;
        end
        if (diff > MAG_CLAMP) begin
            diff = MAG_CLAMP;
        end else begin
            diff = diff;
        end
        return diff;
    endfunction

    // Thermometer bar; full-scale level lights the entire bar.
    function automatic logic [LED_W-1:0] therm_decode(input logic [LEVEL_W-1:0] lvl);
        logic [LED_W-1:0] bar;
        bar = {LED_W{1'b0}};
        for (int i = 0; i < LED_W; i++) begin
            if (i < int'(lvl)) begin
                bar[i] = 1'b1;
            end else begin
                bar[i] = 1'b0;
            end
        end
        if (lvl == 4'd15) begin
            bar = {LED_W{1'b1}};
        end else begin
            bar = bar;
        end
        return bar;
    endfunction

endpackage

// File: rtl/volume_level_ctrl_level_quantizer.sv
// Maps a window's peak magnitude to a 0..15 display level, optionally limiting
// how fast the displayed level may fall.
module level_quantizer
    import volume_level_ctrl_pkg::*;
#(
    parameter int DECAY = 1
) (
    input  logic [SAMPLE_W-1:0] mag_max,
    input  logic [LEVEL_W-1:0]  prev_level,
    output logic [LEVEL_W-1:0]  new_level
);

    logic [SAMPLE_W-1:0] shifted_s;
    logic [LEVEL_W-1:0]  raw_s;
    logic [LEVEL_W-1:0]  floor_s;

    // Coarse level from the peak, then the decay floor one step below the old level.
    always_comb begin
        shifted_s = mag_max >> 7;
        if (shifted_s > 12'd15) begin
            raw_s = 4'd15;
        end else begin
            raw_s = shifted_s[LEVEL_W-1:0];
        end

        if (prev_level == 4'd0) begin
            floor_s = 4'd0;
        end else begin
            floor_s = prev_level - 4'd1;
        end

        if ((DECAY != 0) && (raw_s < floor_s)) begin
            new_level = floor_s;
        end else begin
            new_level = raw_s;
        end
    end

endmodule

// File: rtl/volume_level_ctrl.sv
// Windowed peak volume meter: collects WINDOW samples, quantizes the peak to a
// 4-bit level and publishes level, LED bar and peak with a one-cycle valid pulse.
module volume_level_ctrl
    import volume_level_ctrl_pkg::*;
#(
    parameter int WINDOW   = 4000,
    parameter int DECAY    = 1,
    parameter int MIDPOINT = 2048
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] mic_in,
    input  logic                freeze,
    output logic [LEVEL_W-1:0]  level,
    output logic [LED_W-1:0]    led,
    output logic [SAMPLE_W-1:0] peak,
    output logic                level_valid
);

    localparam logic [CNT_W-1:0]    WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [SAMPLE_W-1:0] MID_CODE = SAMPLE_W'(MIDPOINT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] max_q, max_d;
    logic [LEVEL_W-1:0]  new_level_q, new_level_d;
    logic [SAMPLE_W-1:0] peak_pend_q, peak_pend_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic                valid_q, valid_d;

    logic [SAMPLE_W-1:0] mag_s;
    logic [LEVEL_W-1:0]  quant_level_s;

    level_quantizer #(
        .DECAY (DECAY)
    ) u_quant (
        .mag_max    (max_q),
        .prev_level (level_q),
        .new_level  (quant_level_s)
    );

    // Next-state and datapath; freeze holds every register and suppresses the pulse.
    always_comb begin
        mag_s       = sample_mag(mic_in, MID_CODE);
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        new_level_d = new_level_q;
        peak_pend_d = peak_pend_q;
        level_d     = level_q;
        led_d       = led_q;
        peak_d      = peak_q;
        valid_d     = 1'b0;

        if (freeze) begin
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACQ: begin
                    if (sample_en) begin
                        if (mag_s > max_q) begin
                            max_d = mag_s;
                        end else begin
                            max_d = max_q;
                        end
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == WIN_LAST) begin
                            state_d = ST_QUANT;
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_QUANT: begin
                    new_level_d = quant_level_s;
                    peak_pend_d = max_q;
                    max_d       = {SAMPLE_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    level_d = new_level_q;
                    led_d   = therm_decode(new_level_q);
                    peak_d  = peak_pend_q;
                    valid_d = 1'b1;
                    state_d = ST_ACQ;
                end
                default: begin
                    state_d = ST_ACQ;
                    cnt_d   = {CNT_W{1'b0}};
                    max_d   = {SAMPLE_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_ACQ;
            cnt_q       <= {CNT_W{1'b0}};
            max_q       <= {SAMPLE_W{1'b0}};
            new_level_q <= {LEVEL_W{1'b0}};
            peak_pend_q <= {SAMPLE_W{1'b0}};
            level_q     <= {LEVEL_W{1'b0}};
            led_q       <= {LED_W{1'b0}};
            peak_q      <= {SAMPLE_W{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            new_level_q <= new_level_d;
            peak_pend_q <= peak_pend_d;
            level_q     <= level_d;
            led_q       <= led_d;
            peak_q      <= peak_d;
            valid_q     <= valid_d;
        end
    end

    assign level       = level_q;
    assign led         = led_q;
    assign peak        = peak_q;
    assign level_valid = valid_q;

endmodule

// File: tb/tb_volume_level_ctrl.sv
// Directed bench for volume_level_ctrl with WINDOW=4; runs a DECAY=1 and a
// DECAY=0 instance side by side on identical stimulus.
module tb_volume_level_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic        freeze;
    logic [11:0] mic_in;

    logic [3:0]  level,  level0;
    logic [15:0] led,    led0;
    logic [11:0] peak,   peak0;
    logic        valid,  valid0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    volume_level_ctrl #(.WINDOW(4), .DECAY(1), .MIDPOINT(2048)) u_dut (
        .CLK(clk), .reset(reset), .sample_en(sample_en), .mic_in(mic_in),
        .freeze(freeze), .level(level), .led(led), .peak(peak), .level_valid(valid)
    );

    volume_level_ctrl #(.WINDOW(4), .DECAY(0), .MIDPOINT(2048)) u_dut0 (
        .CLK(clk), .reset(reset), .sample_en(sample_en), .mic_in(mic_in),
        .freeze(freeze), .level(level0), .led(led0), .peak(peak0), .level_valid(valid0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bar_of(input int l);
        logic [15:0] one;
        one = 16'h0001;
        if (l == 15) return 16'hFFFF;
        return (one << l) - 16'h0001;
    endfunction

    // One-cycle strobe; returns on the falling edge right after the accepting edge.
    task automatic strobe(input logic [11:0] v);
        @(negedge clk);
        mic_in    = v;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input int lvl, input int lvl0, input int pk);
        check_eq({tag, ".valid"},  valid,  1'b1);
        check_eq({tag, ".valid0"}, valid0, 1'b1);
        check_eq({tag, ".level"},  level,  lvl);
        check_eq({tag, ".level0"}, level0, lvl0);
        check_eq({tag, ".led"},    led,    bar_of(lvl));
        check_eq({tag, ".led0"},   led0,   bar_of(lvl0));
        check_eq({tag, ".peak"},   peak,   pk);
        check_eq({tag, ".peak0"},  peak0,  pk);
    endtask

    task automatic run_window(input string tag, input logic [11:0] s0, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [11:0] s3,
                              input int lvl, input int lvl0, input int pk);
        strobe(s0);
        check_eq({tag, ".gap0"}, valid, 1'b0);
        strobe(s1);
        check_eq({tag, ".gap1"}, valid, 1'b0);
        strobe(s2);
        check_eq({tag, ".gap2"}, valid, 1'b0);
        strobe(s3);
        @(negedge clk);
        check_eq({tag, ".lat1"}, valid, 1'b0);
        @(negedge clk);
        check_outputs(tag, lvl, lvl0, pk);
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        freeze    = 1'b0;
        mic_in    = 12'd2048;
        repeat (3) @(negedge clk);
        check_eq("rst.level", level, 4'd0);
        check_eq("rst.led",   led,   16'h0000);
        check_eq("rst.peak",  peak,  12'd0);
        check_eq("rst.valid", valid, 1'b0);
        reset = 1'b0;

        run_window("a", 12'd2048, 12'd2048, 12'd2048, 12'd3000, 7, 7, 952);
        run_window("b", 12'd2048, 12'd2048, 12'd2048, 12'd2048, 6, 0, 0);
        run_window("c", 12'd2048, 12'd2048, 12'd2048, 12'd2048, 5, 0, 0);
        run_window("d", 12'd0,    12'd4095, 12'd2048, 12'd2048, 15, 15, 2047);

        // Freeze across three strobes mid-window.
        strobe(12'd2304);
        strobe(12'd2304);
        @(negedge clk);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(12'd0);
            check_eq("frz.valid",  valid,  1'b0);
            check_eq("frz.valid0", valid0, 1'b0);
        end
        @(negedge clk);
        freeze = 1'b0;
        strobe(12'd2304);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("frz.held", valid, 1'b0);
        end
        strobe(12'd2304);
        @(negedge clk);
        check_eq("frz.lat1", valid, 1'b0);
        @(negedge clk);
        check_outputs("frz", 14, 2, 256);

        // Freeze right after the final sample stalls the result until release.
        strobe(12'd2048);
        strobe(12'd2048);
        strobe(12'd2048);
        strobe(12'd2048);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall.valid", valid, 1'b0);
        end
        freeze = 1'b0;
        @(negedge clk);
        check_eq("stall.lat1", valid, 1'b0);
        @(negedge clk);
        check_outputs("stall", 13, 0, 0);

        // Reset in the middle of a loud window.
        strobe(12'd3548);
        strobe(12'd3548);
        strobe(12'd3548);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mrst.level", level, 4'd0);
        check_eq("mrst.led",   led,   16'h0000);
        check_eq("mrst.peak",  peak,  12'd0);
        check_eq("mrst.valid", valid, 1'b0);
        reset = 1'b0;
        run_window("f", 12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 0);

        // Strobes landing on the QUANT and PUBLISH cycles are dropped.
        strobe(12'd2048);
        strobe(12'd2048);
        strobe(12'd2048);
        @(negedge clk);
        mic_in    = 12'd2304;
        sample_en = 1'b1;
        @(negedge clk);
        mic_in = 12'd0;
        @(negedge clk);
        check_eq("drop.lat1", valid, 1'b0);
        @(negedge clk);
        sample_en = 1'b0;
        check_outputs("drop", 2, 2, 256);
        run_window("h", 12'd2048, 12'd2048, 12'd2048, 12'd2048, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
